// File: rtl/switch_allocator.sv
// switch_allocator
// Allocation stage for the 5x5 router crossbar. Each output port runs its own
// round-robin arbiter with wormhole locking, so a packet keeps its output from
// head flit to tail flit. The stage produces the crossbar's one-hot per-output
// input selects and the per-input grants that pop the input buffers.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   req_valid  [4:0]   input j presents a flit this cycle
//   req_dest   [14:0]  requested output of input j at bits [3j+2:3j]
//   req_tail   [4:0]   presented flit is the last of its packet
//   out_ready  [4:0]   downstream of output o accepts a flit this cycle
//   sel0..sel4 [4:0]   one-hot input select per crossbar output (0 = idle)
//   grant      [4:0]   input j's flit is transferred this cycle
//   out_valid  [4:0]   registered; output o of the crossbar carries a flit
//   bad_dest           sticky flag: a valid request named an output > 4
//
// Only NPORTS = 5 is supported; it must match the crossbar.
module switch_allocator #(
  parameter int NPORTS  = 5,
  parameter int DEST_W  = 3,
  parameter bit LOCK_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NPORTS-1:0]        req_valid,
  input  logic [NPORTS*DEST_W-1:0] req_dest,
  input  logic [NPORTS-1:0]        req_tail,
  input  logic [NPORTS-1:0]        out_ready,
  output logic [NPORTS-1:0]        sel0,
  output logic [NPORTS-1:0]        sel1,
  output logic [NPORTS-1:0]        sel2,
  output logic [NPORTS-1:0]        sel3,
  output logic [NPORTS-1:0]        sel4,
  output logic [NPORTS-1:0]        grant,
  output logic [NPORTS-1:0]        out_valid,
  output logic                     bad_dest
);

  localparam int IDW = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t            state_q [NPORTS];
  state_t            state_d [NPORTS];
  logic [IDW-1:0]    owner_q [NPORTS];
  logic [IDW-1:0]    owner_d [NPORTS];
  logic [IDW-1:0]    ptr_q   [NPORTS];
  logic [IDW-1:0]    ptr_d   [NPORTS];
  logic [IDW-1:0]    win     [NPORTS];
  logic [NPORTS-1:0] elig    [NPORTS];
  logic [NPORTS-1:0] sel     [NPORTS];
  logic [NPORTS-1:0] bad_req;

  // First requester found scanning ptr, ptr+1, ... modulo NPORTS.
  function automatic logic [IDW-1:0] rr_pick(input logic [NPORTS-1:0] req,
                                             input logic [IDW-1:0]    ptr);
    logic [IDW-1:0] pick;
    logic           found;
    logic [IDW:0]   idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NPORTS; k++) begin
      idx = {1'b0, ptr} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NPORTS)) idx = idx - (IDW+1)'(NPORTS);
      if (!found && req[idx[IDW-1:0]]) begin
        pick  = idx[IDW-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] j);
    return (j == IDW'(NPORTS-1)) ? '0 : j + 1'b1;
  endfunction

  // Destinations above the last port never match any output, so such
  // requests drop out of arbitration and only raise bad_req.
  always_comb begin
    bad_req = '0;
    for (int o = 0; o < NPORTS; o++) elig[o] = '0;
    for (int j = 0; j < NPORTS; j++) begin
      bad_req[j] = req_valid[j] &&
                   (req_dest[j*DEST_W +: DEST_W] > DEST_W'(NPORTS-1));
      for (int o = 0; o < NPORTS; o++)
        elig[o][j] = req_valid[j] && (req_dest[j*DEST_W +: DEST_W] == DEST_W'(o));
    end
  end

  // Per-output arbitration and lock update. Holding rst_n low forces every
  // select to zero; the state itself is cleared by the register below.
  always_comb begin
    for (int o = 0; o < NPORTS; o++) begin
      sel[o]     = '0;
      win[o]     = '0;
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      ptr_d[o]   = ptr_q[o];
    end
    if (rst_n) begin
      for (int o = 0; o < NPORTS; o++) begin
        case (state_q[o])
          IDLE: begin
            if (out_ready[o] && (|elig[o])) begin
              win[o] = rr_pick(elig[o], ptr_q[o]);
              sel[o] = NPORTS'(1) << win[o];
              if (req_tail[win[o]] || !LOCK_EN) begin
                ptr_d[o] = next_ptr(win[o]);
              end else begin
                state_d[o] = LOCKED;
                owner_d[o] = win[o];
              end
            end
          end
          LOCKED: begin
            // Only the owner can use a locked output; an owner that stalls or
            // points elsewhere simply leaves the output idle.
            if (out_ready[o] && elig[o][owner_q[o]]) begin
              sel[o] = NPORTS'(1) << owner_q[o];
              if (req_tail[owner_q[o]]) begin
                state_d[o] = IDLE;
                ptr_d[o]   = next_ptr(owner_q[o]);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Each input targets one output, so OR-ing the selects yields at most one
  // grant bit per input.
  always_comb begin
    grant = '0;
    for (int o = 0; o < NPORTS; o++) grant = grant | sel[o];
  end

  assign sel0 = sel[0];
  assign sel1 = sel[1];
  assign sel2 = sel[2];
  assign sel3 = sel[3];
  assign sel4 = sel[4];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int o = 0; o < NPORTS; o++) begin
        state_q[o] <= IDLE;
        owner_q[o] <= '0;
        ptr_q[o]   <= '0;
      end
      out_valid <= '0;
      bad_dest  <= 1'b0;
    end else begin
      for (int o = 0; o < NPORTS; o++) begin
        state_q[o]   <= state_d[o];
        owner_q[o]   <= owner_d[o];
        ptr_q[o]     <= ptr_d[o];
        out_valid[o] <= |sel[o];
      end
      bad_dest <= bad_dest | (|bad_req);
    end
  end

endmodule
